// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the PC through a combinational instruction
// memory, buffers {pc, instr} pairs in a small prefetch FIFO and serves them to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [31:0]   EBREAK = 32'h0010_0073;
    localparam int            PW     = (DEPTH > 2) ? 2 : 1;
    localparam int            CW     = (DEPTH > 3) ? 3 : 2;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t        state;
    logic [31:0]   pc_q;
    logic [31:0]   pc_buf    [DEPTH];
    logic [31:0]   instr_buf [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign imem_addr = pc_q;
    assign if_pc     = pc_buf[rd_ptr];
    assign if_instr  = instr_buf[rd_ptr];
    assign if_valid  = (count != '0) & ~redirect_valid;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    always_comb begin
        pop   = if_valid & if_ready;
        flush = redirect_valid & (state != ST_IDLE);
        push  = (state == ST_RUN) & ~redirect_valid & ((count != FULL) | pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_buf[i]    <= '0;
                instr_buf[i] <= '0;
            end
        end else if (flush) begin
            // Redirect discards everything buffered, including a same-cycle pop.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_q   <= {redirect_pc[31:2], 2'b00};
            halted <= 1'b0;
            state  <= (state == ST_HALTED || fetch_en) ? ST_RUN : ST_IDLE;
        end else begin
            if (push) begin
                pc_buf[wr_ptr]    <= pc_q;
                instr_buf[wr_ptr] <= imem_instr;
                wr_ptr            <= ptr_inc(wr_ptr);
                pc_q              <= pc_q + 32'd4;
                fetch_count       <= fetch_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case (state)
                ST_IDLE: begin
                    if (fetch_en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push && imem_instr == EBREAK) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else if (!fetch_en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of per-cycle vectors with hand-computed
// outputs, followed by a hand-written PC / fetch_count wrap-around sequence.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic        prog;
    logic [31:0] prog_words [4];
    int          total_checks;
    int          passed_checks;

    typedef struct {
        logic        rst;
        logic        prog;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
        logic        ehalt;
        logic [15:0] efc;
    } vec_t;

    vec_t vecs[$];

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_en(fetch_en),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: the short program at 0x0..0xC in prog mode, otherwise {addr[15:0], NOP-ish low half}.
    assign imem_instr = (prog && imem_addr < 32'h10) ? prog_words[imem_addr[3:2]]
                                                     : {imem_addr[15:0], 16'h0013};

    task automatic applyStimulus(input logic rst, input logic pm, input logic fe,
                                 input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset_n        = ~rst;
        prog           = pm;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic addVec(input logic rst, input logic pm, input logic fe, input logic rdy,
                          input logic rv, input logic [31:0] rpc, input logic ev,
                          input logic [31:0] epc, input logic [31:0] einstr,
                          input logic [31:0] eaddr, input logic ehalt, input logic [15:0] efc);
        vec_t v;
        v.rst = rst; v.prog = pm; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr; v.ehalt = ehalt; v.efc = efc;
        vecs.push_back(v);
    endtask

    initial begin
        int waited;
        total_checks   = 0;
        passed_checks  = 0;
        reset_n        = 1'b0;
        prog           = 1'b1;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        prog_words[0]  = 32'h0050_0093;
        prog_words[1]  = 32'h00A0_0113;
        prog_words[2]  = 32'h0020_81B3;
        prog_words[3]  = 32'h0010_0073;

        // rst prog fe rdy rv rpc | ev epc einstr eaddr halt fc
        // Program run ending in EBREAK, then redirect out of HALTED to 0x23 -> 0x20.
        addVec(1, 1, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 1, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 1, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 1, 1, 1, 0, 32'h0,  1, 32'h0,  32'h0050_0093, 32'h4,  0, 16'd1);
        addVec(0, 1, 1, 1, 0, 32'h0,  1, 32'h4,  32'h00A0_0113, 32'h8,  0, 16'd2);
        addVec(0, 1, 1, 1, 0, 32'h0,  1, 32'h8,  32'h0020_81B3, 32'hC,  0, 16'd3);
        addVec(0, 1, 1, 1, 0, 32'h0,  1, 32'hC,  32'h0010_0073, 32'h10, 1, 16'd4);
        addVec(0, 1, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h10, 1, 16'd4);
        addVec(0, 1, 0, 1, 1, 32'h23, 0, 32'h0,  32'h0,         32'h10, 1, 16'd4);
        addVec(0, 1, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h20, 0, 16'd4);
        addVec(0, 1, 1, 1, 0, 32'h0,  1, 32'h20, 32'h0020_0013, 32'h24, 0, 16'd5);
        // Back-pressure: FIFO fills, PC holds at 8, then 0,4,8 drain back to back.
        addVec(1, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0000_0013, 32'h4,  0, 16'd1);
        addVec(0, 0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0000_0013, 32'h8,  0, 16'd2);
        addVec(0, 0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0000_0013, 32'h8,  0, 16'd2);
        addVec(0, 0, 1, 1, 0, 32'h0,  1, 32'h0,  32'h0000_0013, 32'h8,  0, 16'd2);
        addVec(0, 0, 1, 1, 0, 32'h0,  1, 32'h4,  32'h0004_0013, 32'hC,  0, 16'd3);
        addVec(0, 0, 1, 0, 0, 32'h0,  1, 32'h8,  32'h0008_0013, 32'h10, 0, 16'd4);
        // One-cycle reset with two entries buffered; stays IDLE while fetch_en=0.
        addVec(1, 0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        // Redirect to 0x40 while FIFO holds pc 4 and 8, with a same-cycle pop attempt.
        addVec(0, 0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 1, 0, 0, 32'h0,  0, 32'h0,  32'h0,         32'h0,  0, 16'd0);
        addVec(0, 0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h0000_0013, 32'h4,  0, 16'd1);
        addVec(0, 0, 1, 1, 0, 32'h0,  1, 32'h0,  32'h0000_0013, 32'h8,  0, 16'd2);
        addVec(0, 0, 1, 1, 1, 32'h40, 0, 32'h0,  32'h0,         32'hC,  0, 16'd3);
        addVec(0, 0, 1, 1, 0, 32'h0,  0, 32'h0,  32'h0,         32'h40, 0, 16'd3);
        addVec(0, 0, 1, 1, 0, 32'h0,  1, 32'h40, 32'h0040_0013, 32'h44, 0, 16'd4);
        addVec(0, 0, 1, 1, 0, 32'h0,  1, 32'h44, 32'h0044_0013, 32'h48, 0, 16'd5);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].prog, vecs[i].fe, vecs[i].rdy,
                          vecs[i].rv, vecs[i].rpc);
            checkOutput($sformatf("row%0d if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].ev});
            checkOutput($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            checkOutput($sformatf("row%0d halted", i), {31'h0, halted}, {31'h0, vecs[i].ehalt});
            checkOutput($sformatf("row%0d fetch_count", i), {16'h0, fetch_count}, {16'h0, vecs[i].efc});
            if (vecs[i].ev || vecs[i].rst) begin
                checkOutput($sformatf("row%0d if_pc", i), if_pc, vecs[i].epc);
                checkOutput($sformatf("row%0d if_instr", i), if_instr, vecs[i].einstr);
            end
        end

        // Stream until fetch_count reaches 0xFFFF, then check the wrap and a PC wrap.
        applyStimulus(1, 0, 0, 1, 0, 32'h0);
        waited = 0;
        while (fetch_count != 16'hFFFF && waited < 70000) begin
            applyStimulus(0, 0, 1, 1, 0, 32'h0);
            waited++;
        end
        checkOutput("wrap fetch_count reaches FFFF", {16'h0, fetch_count}, 32'h0000_FFFF);
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        checkOutput("wrap fetch_count to 0", {16'h0, fetch_count}, 32'h0);
        applyStimulus(0, 0, 1, 1, 1, 32'hFFFF_FFFE);
        checkOutput("wrap redirect if_valid", {31'h0, if_valid}, 32'h0);
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        checkOutput("wrap imem_addr top", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        checkOutput("wrap imem_addr zero", imem_addr, 32'h0000_0000);
        checkOutput("wrap if_valid", {31'h0, if_valid}, 32'h1);
        checkOutput("wrap if_pc", if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap if_instr", if_instr, 32'hFFFC_0013);
        checkOutput("wrap fetch_count", {16'h0, fetch_count}, 32'h2);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch controller that sequences the combinational instruction memory (`inst_mem`: address in, 32-bit instruction out in the same cycle).
- Holds the PC and reads one word per cycle into a 2-entry prefetch FIFO.
- Hands {pc, instr} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects and halts fetch on EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; legal range 2..4.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  start/continue fetching; sampled every cycle.
- imem_addr  output  32  byte address to `inst_mem`; always equals pc_q.
- imem_instr  input  32  instruction returned combinationally for imem_addr.
- if_valid  output  1  FIFO head valid toward decode.
- if_ready  input  1  decode accepts head.
- if_pc  output  32  PC of head entry.
- if_instr  output  32  instruction of head entry.
- redirect_valid  input  1  branch/jump taken; flush and restart.
- redirect_pc  input  32  new PC; bits [1:0] forced to 0.
- halted  output  1  fetch stopped after EBREAK.
- fetch_count  output  16  number of words pushed since reset; wraps.

Behaviour:
- Reset (async, reset_n=0):
  - pc_q=RESET_PC, FIFO empty, state=IDLE.
  - if_valid=0, if_pc=0, if_instr=0, halted=0, fetch_count=0.
  - imem_addr=RESET_PC.
- Reset deassertion mid-operation discards all FIFO contents; nothing survives.
- States:
  - IDLE -> RUN when fetch_en=1.
  - RUN -> IDLE when fetch_en=0 (FIFO retained, no new pushes).
  - RUN -> HALTED when a pushed word equals 32'h0010_0073 (EBREAK).
  - HALTED -> RUN only on redirect_valid; fetch_en is ignored in HALTED.
- Push, in RUN only:
  - Condition: push = (count<DEPTH) | (count==DEPTH & pop), and redirect_valid=0.
  - On push: entry {pc_q, imem_instr} is written, pc_q<=pc_q+4 (wraps at 2^32), fetch_count<=fetch_count+1.
  - Latency: the word at address A is visible on if_* the cycle after A is presented, when the FIFO was empty.
  - The EBREAK word itself is pushed and delivered. pc_q stops at EBREAK+4 and no further pushes occur.
- Pop: pop = if_valid & if_ready. Head advances the next cycle; if_pc/if_instr are stable while if_valid=1 & if_ready=0.
- if_valid = (count!=0) & ~redirect_valid.
- Redirect (any state except IDLE):
  - FIFO is flushed; a pop in the same cycle is void.
  - pc_q<={redirect_pc[31:2],2'b00}.
  - No push that cycle; HALTED -> RUN.
  - The first post-redirect word appears on if_* 2 cycles after the redirect cycle.
- Simultaneous redirect and EBREAK push: redirect wins; no halt.
- Full FIFO with pop: push and pop in the same cycle; count is unchanged.
- Full FIFO without pop: pc_q holds; imem_addr is stable.
- fetch_en=0 in RUN: already-buffered entries keep draining.

Test Plan:
- Reset, fetch_en=1, if_ready=1, memory words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00100073:
  - if_valid rises 1 cycle after RUN entry.
  - if_pc sequence 0,4,8,12 on consecutive cycles.
  - halted=1 after 0xC is pushed; fetch_count=4; no push of 0x10.
- if_ready=0 with a continuous stream:
  - FIFO fills to 2 entries; imem_addr holds at 8.
  - if_pc=0 stable.
  - Raise if_ready: pc 0,4,8 delivered with no gaps or duplicates.
- Redirect to 0x40 while FIFO holds pc 4 and 8, with if_ready=1 in the same cycle:
  - if_valid=0 that cycle; pop void.
  - Next delivered if_pc=0x40, then 0x44.
- From HALTED, redirect_pc=0x23:
  - pc_q=0x20, halted=0.
  - Fetch resumes at 0x20 regardless of fetch_en.
- Assert reset_n=0 for 1 cycle mid-stream with 2 entries buffered:
  - Immediately if_valid=0, fetch_count=0, imem_addr=RESET_PC.
  - State IDLE until fetch_en is seen.
- pc_q=0xFFFF_FFFC with continuous fetch:
  - Next fetch address is 0x0000_0000.
  - fetch_count at 0xFFFF then wraps to 0x0000 on the next push.
